// File: rtl/sprite_compositor_if.sv
// Bus bundle for sprite_compositor: pixel stream in, shadow-register config,
// per-channel external sprite ROM port and composited pixel out.
// The master modport belongs to the pixel source/config side; the slave
// modport belongs to the compositor.
interface sprite_compositor_if #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned XW      = 10,
    parameter int unsigned YW      = 10,
    parameter int unsigned DW      = 12,
    parameter int unsigned AW      = 12,
    parameter int unsigned SW      = 6,
    parameter int unsigned NFRAMES = 4
);
    localparam int unsigned CSW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned FW  = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;

    logic              frame_start;
    logic              px_valid;
    logic [XW-1:0]     px_x;
    logic [YW-1:0]     px_y;
    logic [DW-1:0]     bg_color;
    logic              cfg_wr;
    logic [CSW-1:0]    cfg_sel;
    logic [XW-1:0]     cfg_x;
    logic [YW-1:0]     cfg_y;
    logic [SW-1:0]     cfg_w;
    logic [SW-1:0]     cfg_h;
    logic              cfg_en;
    logic              cfg_anim;
    logic [NCH*AW-1:0] rom_addr;
    logic [NCH*DW-1:0] rom_data;
    logic              out_valid;
    logic [DW-1:0]     out_rgb;
    logic [NCH-1:0]    out_hit;
    logic [FW-1:0]     anim_frame;
    logic              collide;

    modport master (
        output frame_start, px_valid, px_x, px_y, bg_color,
        output cfg_wr, cfg_sel, cfg_x, cfg_y, cfg_w, cfg_h, cfg_en, cfg_anim,
        output rom_data,
        input  rom_addr, out_valid, out_rgb, out_hit, anim_frame, collide
    );

    modport slave (
        input  frame_start, px_valid, px_x, px_y, bg_color,
        input  cfg_wr, cfg_sel, cfg_x, cfg_y, cfg_w, cfg_h, cfg_en, cfg_anim,
        input  rom_data,
        output rom_addr, out_valid, out_rgb, out_hit, anim_frame, collide
    );
endinterface

// File: rtl/sprite_compositor.sv
// Pipelined sprite compositor: overlays NCH priority-ordered sprite channels
// (channel 0 on top) on a background colour, with colour-key transparency,
// strip animation and frame-start double-buffered sprite positions.
// Stage 0: hit test + ROM address; stage 1: registered ROM address;
// stage 2: ROM data keyed/prioritised into registered outputs.
// Optional feature macro: SPRITE_COLLISION_EN (sticky channel-0 collision flag).
module sprite_compositor #(
    parameter int unsigned    NCH     = 4,
    parameter int unsigned    XW      = 10,
    parameter int unsigned    YW      = 10,
    parameter int unsigned    DW      = 12,
    parameter int unsigned    AW      = 12,
    parameter int unsigned    SW      = 6,
    parameter logic [DW-1:0]  KEY     = 12'h00f,
    parameter int unsigned    NFRAMES = 4,
    parameter int unsigned    FDIV    = 8
) (
    input logic               clk,
    input logic               clrn,
    sprite_compositor_if.slave bus
);
    localparam int unsigned CSW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned FW   = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
    localparam int unsigned DIVW = (FDIV > 1) ? $clog2(FDIV) : 1;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [SW-1:0] w;
        logic [SW-1:0] h;
        logic          en;
        logic          anim;
    } ch_cfg_t;

    ch_cfg_t           sh_q  [NCH];
    ch_cfg_t           act_q [NCH];
    ch_cfg_t           cfg_in;
    logic [NCH-1:0]    wr_sel;

    logic [DIVW-1:0]   div_q;
    logic [FW-1:0]     anim_q;

    logic [XW-1:0]     dx  [NCH];
    logic [YW-1:0]     dy  [NCH];
    logic [31:0]       lin [NCH];
    logic [NCH-1:0]    hit0;
    logic [NCH*AW-1:0] addr0;

    logic [NCH*AW-1:0] rom_addr_q;
    logic [NCH-1:0]    hit1_q;
    logic [DW-1:0]     bg1_q;
    logic              v1_q;

    logic [NCH-1:0]    vis;
    logic [DW-1:0]     rgb_sel;

    logic              out_valid_q;
    logic [DW-1:0]     out_rgb_q;
    logic [NCH-1:0]    out_hit_q;

    // Decode the config write into a per-channel strobe and pack the write data.
    always_comb begin
        cfg_in.x    = bus.cfg_x;
        cfg_in.y    = bus.cfg_y;
        cfg_in.w    = bus.cfg_w;
        cfg_in.h    = bus.cfg_h;
        cfg_in.en   = bus.cfg_en;
        cfg_in.anim = bus.cfg_anim;
        wr_sel      = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i] = bus.cfg_wr && (bus.cfg_sel == CSW'(i));
        end
    end

    // Shadow registers take writes; frame_start promotes shadow to active.
    // A write coincident with frame_start bypasses straight into active.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NCH; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_sel[i]) begin
                    sh_q[i] <= cfg_in;
                end
                if (bus.frame_start) begin
                    act_q[i] <= wr_sel[i] ? cfg_in : sh_q[i];
                end
            end
        end
    end

    // Animation divider: one frame step every FDIV frame_start pulses.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            div_q  <= '0;
            anim_q <= '0;
        end else if (bus.frame_start) begin
            if (div_q == DIVW'(FDIV - 1)) begin
                div_q  <= '0;
                anim_q <= (anim_q == FW'(NFRAMES - 1)) ? '0 : anim_q + FW'(1);
            end else begin
                div_q <= div_q + DIVW'(1);
            end
        end
    end

    // Stage 0: modular-offset hit test and linear sprite ROM address.
    // Unsigned wrap makes sprites hanging off the left/top edge clip for free.
    always_comb begin
        hit0  = '0;
        addr0 = '0;
        for (int i = 0; i < NCH; i++) begin
            dx[i]   = bus.px_x - act_q[i].x;
            dy[i]   = bus.px_y - act_q[i].y;
            hit0[i] = bus.px_valid && act_q[i].en &&
                      (32'(dx[i]) < 32'(act_q[i].w)) &&
                      (32'(dy[i]) < 32'(act_q[i].h));
            lin[i]  = 32'(dy[i]) * 32'(act_q[i].w);
            if (act_q[i].anim) begin
                // Animation strip: frames sit side by side, NFRAMES*w pixels per row.
                lin[i] = lin[i] * NFRAMES + 32'(anim_q) * 32'(act_q[i].w);
            end
            lin[i] = lin[i] + 32'(dx[i]);
            if (hit0[i]) begin
                addr0[i*AW +: AW] = lin[i][AW-1:0];
            end
        end
    end

    // Stage 1: register ROM addresses alongside hit mask, background and valid.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rom_addr_q <= '0;
            hit1_q     <= '0;
            bg1_q      <= '0;
            v1_q       <= 1'b0;
        end else begin
            rom_addr_q <= addr0;
            hit1_q     <= hit0;
            bg1_q      <= bus.bg_color;
            v1_q       <= bus.px_valid;
        end
    end

    // Stage 2: drop keyed pixels, then pick the lowest-index opaque channel.
    always_comb begin
        vis     = '0;
        rgb_sel = bg1_q;
        for (int i = NCH - 1; i >= 0; i--) begin
            vis[i] = hit1_q[i] && (bus.rom_data[i*DW +: DW] != KEY);
            if (vis[i]) begin
                rgb_sel = bus.rom_data[i*DW +: DW];
            end
        end
    end

    // Output register; bubbles present zero colour and an empty hit mask.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
            out_hit_q   <= '0;
        end else begin
            out_valid_q <= v1_q;
            out_rgb_q   <= v1_q ? rgb_sel : '0;
            out_hit_q   <= v1_q ? vis : '0;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic coll_now;
    logic collide_q;

    // Channel 0 overlapping any other opaque channel on the same pixel.
    always_comb begin
        coll_now = 1'b0;
        for (int i = 1; i < NCH; i++) begin
            coll_now = coll_now | (vis[0] && vis[i]);
        end
    end

    // Sticky flag, cleared by frame_start unless a new collision lands that cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            collide_q <= 1'b0;
        end else if (coll_now) begin
            collide_q <= 1'b1;
        end else if (bus.frame_start) begin
            collide_q <= 1'b0;
        end
    end

    assign bus.collide = collide_q;
`else
    assign bus.collide = 1'b0;
`endif

    assign bus.rom_addr   = rom_addr_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_rgb    = out_rgb_q;
    assign bus.out_hit    = out_hit_q;
    assign bus.anim_frame = anim_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a cycle-stamped scoreboard of
// expected composited pixels. Build with SPRITE_COLLISION_EN to expect the
// sticky collision flag; without it collide must stay 0.
module tb_sprite_compositor;
    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 12;
    localparam int unsigned AW  = 12;

`ifdef SPRITE_COLLISION_EN
    localparam logic CollEn = 1'b1;
`else
    localparam logic CollEn = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic [3:0]  hit;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [11:0] rom_tab [NCH];

    sprite_compositor_if #(
        .NCH(4), .XW(10), .YW(10), .DW(12), .AW(12), .SW(6), .NFRAMES(4)
    ) bus ();

    sprite_compositor #(
        .NCH(4), .XW(10), .YW(10), .DW(12), .AW(12), .SW(6),
        .KEY(12'h00f), .NFRAMES(4), .FDIV(2)
    ) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench ROM: each channel returns a programmable colour.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            bus.rom_data[c*DW +: DW] = rom_tab[c];
        end
    end

    // Output monitor: a due scoreboard entry must appear exactly now; else a bubble.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            checks++;
            assert (bus.out_valid === 1'b1 && bus.out_rgb === sb[0].rgb &&
                    bus.out_hit === sb[0].hit)
            else begin
                errors++;
                $error("FAIL pixel observed v=%b rgb=%h hit=%b expected v=1 rgb=%h hit=%b",
                       bus.out_valid, bus.out_rgb, bus.out_hit, sb[0].rgb, sb[0].hit);
            end
            void'(sb.pop_front());
        end else begin
            checks++;
            assert (bus.out_valid === 1'b0 && bus.out_rgb === 12'h000 &&
                    bus.out_hit === 4'b0000)
            else begin
                errors++;
                $error("FAIL bubble observed v=%b rgb=%h hit=%b expected v=0 rgb=000 hit=0000",
                       bus.out_valid, bus.out_rgb, bus.out_hit);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int x, input int y, input logic [11:0] bg,
                         input logic [11:0] exp_rgb, input logic [3:0] exp_hit);
        exp_t e;
        @(negedge clk);
        bus.px_valid = 1'b1;
        bus.px_x     = x[9:0];
        bus.px_y     = y[9:0];
        bus.bg_color = bg;
        e.due = cyc + 2;
        e.rgb = exp_rgb;
        e.hit = exp_hit;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.px_valid = 1'b0;
    endtask

    task automatic cfg(input int ch, input int x, input int y, input int w, input int h,
                       input logic en, input logic anim, input logic fs);
        @(negedge clk);
        bus.cfg_wr      = 1'b1;
        bus.cfg_sel     = ch[1:0];
        bus.cfg_x       = x[9:0];
        bus.cfg_y       = y[9:0];
        bus.cfg_w       = w[5:0];
        bus.cfg_h       = h[5:0];
        bus.cfg_en      = en;
        bus.cfg_anim    = anim;
        bus.frame_start = fs;
        @(posedge clk);
        #1;
        bus.cfg_wr      = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic fstart();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic check_addr(input int ch, input int exp);
        logic [AW-1:0] a;
        a = bus.rom_addr[ch*AW +: AW];
        chk($sformatf("rom_addr%0d", ch), 32'(a), exp);
    endtask

    initial begin
        clrn            = 1'b0;
        bus.frame_start = 1'b0;
        bus.px_valid    = 1'b1;
        bus.px_x        = '0;
        bus.px_y        = '0;
        bus.bg_color    = 12'h777;
        bus.cfg_wr      = 1'b0;
        bus.cfg_sel     = '0;
        bus.cfg_x       = '0;
        bus.cfg_y       = '0;
        bus.cfg_w       = '0;
        bus.cfg_h       = '0;
        bus.cfg_en      = 1'b0;
        bus.cfg_anim    = 1'b0;
        rom_tab[0]      = 12'hF00;
        rom_tab[1]      = 12'h0F0;
        rom_tab[2]      = 12'hABC;
        rom_tab[3]      = 12'h333;

        // Reset held with px_valid high.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_rgb", 32'(bus.out_rgb), 0);
        chk("rst_out_hit", 32'(bus.out_hit), 0);
        chk("rst_anim", 32'(bus.anim_frame), 0);
        chk("rst_collide", 32'(bus.collide), 0);
        check_addr(0, 0);
        @(negedge clk);
        clrn         = 1'b1;
        bus.px_valid = 1'b0;

        pixel(0, 0, 12'h123, 12'h123, 4'b0000);

        // Single sprite; config is invisible until frame_start.
        cfg(0, 40, 100, 16, 16, 1'b1, 1'b0, 1'b0);
        pixel(41, 102, 12'h111, 12'h111, 4'b0000);
        fstart();
        pixel(41, 102, 12'h111, 12'hF00, 4'b0001);
        check_addr(0, 33);
        check_addr(1, 0);
        pixel(56, 100, 12'h111, 12'h111, 4'b0000);
        pixel(40, 99, 12'h444, 12'h444, 4'b0000);
        pixel(55, 115, 12'h555, 12'hF00, 4'b0001);
        check_addr(0, 255);

        // Transparency and priority between ch0 and ch1.
        cfg(1, 40, 100, 16, 16, 1'b1, 1'b0, 1'b0);
        fstart();
        idle(2);
        rom_tab[0] = 12'h00F;
        pixel(41, 102, 12'h111, 12'h0F0, 4'b0010);
        idle(2);
        chk("collide_keyed", 32'(bus.collide), 0);
        rom_tab[0] = 12'hF00;
        pixel(41, 102, 12'h111, 12'hF00, 4'b0011);
        idle(2);
        chk("collide_ch1", 32'(bus.collide), 32'(CollEn));
        fstart();
        chk("collide_clr1", 32'(bus.collide), 0);

        // Collision between ch0 and ch2, held until frame_start.
        cfg(1, 40, 100, 16, 16, 1'b0, 1'b0, 1'b0);
        cfg(2, 45, 105, 8, 8, 1'b1, 1'b0, 1'b0);
        fstart();
        pixel(46, 106, 12'h111, 12'hF00, 4'b0101);
        idle(3);
        chk("collide_ch2", 32'(bus.collide), 32'(CollEn));
        idle(3);
        chk("collide_held", 32'(bus.collide), 32'(CollEn));
        fstart();
        chk("collide_clr2", 32'(bus.collide), 0);
        rom_tab[0] = 12'h00F;
        pixel(46, 106, 12'h111, 12'hABC, 4'b0100);
        idle(2);
        chk("collide_none", 32'(bus.collide), 0);
        rom_tab[0] = 12'hF00;

        // Double buffering of positions.
        cfg(2, 45, 105, 8, 8, 1'b0, 1'b0, 1'b0);
        fstart();
        cfg(0, 200, 100, 16, 16, 1'b1, 1'b0, 1'b0);
        pixel(41, 102, 12'h222, 12'hF00, 4'b0001);
        pixel(201, 102, 12'h222, 12'h222, 4'b0000);
        fstart();
        pixel(201, 102, 12'h222, 12'hF00, 4'b0001);
        check_addr(0, 33);
        pixel(41, 102, 12'h222, 12'h222, 4'b0000);
        cfg(0, 40, 100, 16, 16, 1'b1, 1'b0, 1'b1);
        pixel(41, 102, 12'h222, 12'hF00, 4'b0001);
        idle(3);

        // Asynchronous reset with a pixel in flight flushes the pipe.
        pixel(41, 102, 12'h222, 12'hF00, 4'b0001);
        clrn = 1'b0;
        #1;
        chk("midrst_rom_addr", 32'(bus.rom_addr[AW-1:0]), 0);
        chk("midrst_valid", 32'(bus.out_valid), 0);
        sb.delete();
        @(negedge clk);
        clrn = 1'b1;
        pixel(41, 102, 12'h0AB, 12'h0AB, 4'b0000);

        // Animation: FDIV=2, NFRAMES=4.
        cfg(0, 40, 100, 16, 16, 1'b1, 1'b1, 1'b0);
        chk("anim_start", 32'(bus.anim_frame), 0);
        for (int k = 1; k <= 14; k++) begin
            fstart();
            chk($sformatf("anim_k%0d", k), 32'(bus.anim_frame), 32'((k / 2) % 4));
        end
        rom_tab[0] = 12'h5A5;
        pixel(40, 101, 12'h111, 12'h5A5, 4'b0001);
        check_addr(0, 112);

        idle(4);
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
